// File: rtl/vram_access_scheduler.sv
// Purpose : owns the single VRAM port and shares it between queued CPU writes and the background scanline fetch.
// Latency : line_start at cycle k gives the first read at k+1 and the last BSM write plus fetch_done at k+195 when uncontended.
// Backpres: cpu_wr_full (registered) stalls the CPU; a full FIFO takes the port in an issue slot and the fetch re-issues the next cycle.
// Option  : `define VRAM_CPU_PRIORITY_EN to let any queued CPU write beat the fetch in issue slots.
module vram_access_scheduler #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] PMB_BASE   = 12'h200,
  parameter logic [ADDR_WIDTH-1:0] NTBL_BASE  = 12'h400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_wr_cs,
  input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
  input  logic [7:0]            cpu_wr_data,
  output logic                  cpu_wr_full,
  output logic                  overflow,
  input  logic                  line_start,
  input  logic [7:0]            line_y,
  output logic                  fetch_busy,
  output logic                  fetch_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  bsm_we,
  output logic [4:0]            bsm_col,
  output logic [18:0]           bsm_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + 8;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ISS_COL  = 4'd1;
  localparam logic [3:0] WT_COL   = 4'd2;
  localparam logic [3:0] ISS_TILE = 4'd3;
  localparam logic [3:0] WT_TILE  = 4'd4;
  localparam logic [3:0] ISS_LO   = 4'd5;
  localparam logic [3:0] WT_LO    = 4'd6;
  localparam logic [3:0] ISS_HI   = 4'd7;
  localparam logic [3:0] WT_HI    = 4'd8;

  // CPU write FIFO
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             fifo_empty, push, pop;
  logic [ENT_W-1:0] head;

  // fetch engine state
  logic [3:0]            state;
  logic [7:0]            y_q;
  logic [4:0]            col;
  logic [5:0]            colour_q;
  logic                  color_sel, hflip, vflip;
  logic [4:0]            pmba;
  logic [7:0]            lo_q;
  logic                  iss_state, cpu_grant, fetch_re;
  logic [2:0]            yv;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [15:0]           pix_raw, pix_out;
  logic [2:0]            pal;

  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign push       = cpu_wr_cs && !cpu_wr_full;
  assign pop        = cpu_grant;
  assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

  assign iss_state = (state == ISS_COL) || (state == ISS_TILE) ||
                     (state == ISS_LO)  || (state == ISS_HI);

`ifdef VRAM_CPU_PRIORITY_EN
  assign cpu_grant = !fifo_empty;
`else
  assign cpu_grant = !fifo_empty && (!iss_state || cpu_wr_full);
`endif
  assign fetch_re = iss_state && !cpu_grant;

  assign mem_we     = cpu_grant;
  assign mem_re     = fetch_re;
  assign fetch_busy = (state != IDLE);
  assign yv         = vflip ? ~y_q[2:0] : y_q[2:0];

  // FIFO data storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cpu_wr_addr, cpu_wr_data};
  end

  // FIFO pointers, registered full flag and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cpu_wr_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      cpu_wr_full <= (count_nxt == CNT_W'(FIFO_DEPTH));
      if (cpu_wr_cs && cpu_wr_full) overflow <= 1'b1;
    end
  end

  // address the fetch engine wants for its current issue state
  always_comb begin
    fetch_addr = '0;
    case (state)
      ISS_COL:  fetch_addr = NTBL_BASE + ADDR_WIDTH'(960);
      ISS_TILE: fetch_addr = NTBL_BASE + ADDR_WIDTH'({y_q[7:3], col});
      ISS_LO:   fetch_addr = PMB_BASE + ADDR_WIDTH'({pmba, yv, 1'b0});
      ISS_HI:   fetch_addr = PMB_BASE + ADDR_WIDTH'({pmba, yv, 1'b1});
      default:  fetch_addr = '0;
    endcase
  end

  // memory port mux: the granted CPU write or the fetch read, otherwise idle at zero
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_addr  = head[ENT_W-1:8];
      mem_wdata = head[7:0];
    end else if (fetch_re) begin
      mem_addr = fetch_addr;
    end
  end

  // assemble the BSM word: hi byte arrives on mem_rdata during WT_HI, hflip reverses the 2-bit pixels
  always_comb begin
    pix_raw = {lo_q, mem_rdata};
    pix_out = pix_raw;
    if (hflip) begin
      for (int i = 0; i < 8; i++) pix_out[2*i +: 2] = pix_raw[14-2*i +: 2];
    end
    pal = color_sel ? colour_q[5:3] : colour_q[2:0];
  end

  // fetch FSM: issue/wait pairs; the BSM write of a column overlaps the next column's tile issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      y_q        <= '0;
      col        <= '0;
      colour_q   <= '0;
      color_sel  <= 1'b0;
      hflip      <= 1'b0;
      vflip      <= 1'b0;
      pmba       <= '0;
      lo_q       <= '0;
      bsm_we     <= 1'b0;
      bsm_col    <= '0;
      bsm_data   <= '0;
      fetch_done <= 1'b0;
    end else begin
      bsm_we     <= 1'b0;
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (line_start) begin
            y_q   <= line_y;
            col   <= '0;
            state <= ISS_COL;
          end
        end
        ISS_COL:  if (fetch_re) state <= WT_COL;
        ISS_TILE: if (fetch_re) state <= WT_TILE;
        ISS_LO:   if (fetch_re) state <= WT_LO;
        ISS_HI:   if (fetch_re) state <= WT_HI;
        WT_COL: begin
          colour_q <= mem_rdata[5:0];
          state    <= ISS_TILE;
        end
        WT_TILE: begin
          color_sel <= mem_rdata[7];
          hflip     <= mem_rdata[6];
          vflip     <= mem_rdata[5];
          pmba      <= mem_rdata[4:0];
          state     <= ISS_LO;
        end
        WT_LO: begin
          lo_q  <= mem_rdata;
          state <= ISS_HI;
        end
        WT_HI: begin
          bsm_we   <= 1'b1;
          bsm_col  <= col;
          bsm_data <= {pal, pix_out};
          col      <= col + 5'd1;
          if (col == 5'd31) begin
            fetch_done <= 1'b1;
            state      <= IDLE;
          end else begin
            state <= ISS_TILE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Directed bench for vram_access_scheduler with a behavioural VRAM.
// Outputs are sampled on the falling edge; stimulus changes 1 time unit after the rising edge.
// Waits are fixed cycle counts so the run always ends.
module tb_vram_access_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wr_cs;
  logic [11:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_full, overflow;
  logic        line_start;
  logic [7:0]  line_y;
  logic        fetch_busy, fetch_done;
  logic [11:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        bsm_we;
  logic [4:0]  bsm_col;
  logic [18:0] bsm_data;

  vram_access_scheduler dut (
    .clk(clk), .rst(rst),
    .cpu_wr_cs(cpu_wr_cs), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_full(cpu_wr_full), .overflow(overflow),
    .line_start(line_start), .line_y(line_y),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .bsm_we(bsm_we), .bsm_col(bsm_col), .bsm_data(bsm_data)
  );

  always #5 clk = ~clk;

  // behavioural VRAM: write on the edge, read data one cycle after the strobe
  logic [7:0] vmem [4096];
  always @(posedge clk) begin
    if (mem_we) vmem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= vmem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observation log
  int          ls_cyc = 0, first_re_cyc = -1, done_cyc = 0;
  int          done_cnt = 0, bsm_cnt = 0, wr_n = 0, both_cnt = 0;
  logic        saw_full = 1'b0;
  logic [18:0] bsm_mem [32];
  logic [19:0] wr_log [16];

  always @(negedge clk) begin
    if (rst) begin
      if (line_start && !fetch_busy) begin
        ls_cyc = cyc;
        first_re_cyc = -1;
      end
      if (mem_re && first_re_cyc < 0) first_re_cyc = cyc;
      if (mem_re && mem_we) both_cnt++;
      if (fetch_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bsm_we) begin
        bsm_cnt++;
        bsm_mem[bsm_col] = bsm_data;
      end
      if (mem_we) begin
        if (wr_n < 16) wr_log[wr_n] = {mem_addr, mem_wdata};
        wr_n++;
      end
      if (cpu_wr_full) saw_full = 1'b1;
    end
  end

  int checks = 0, passes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    done_cnt = 0;
    bsm_cnt  = 0;
    wr_n     = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 32; i++) bsm_mem[i] = 19'h0;
  endtask

  task automatic start_line(input logic [7:0] y);
    line_y     = y;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  logic [11:0] t3_addr [4];
  logic [7:0]  t3_data [4];
  int          t4_idx  [7];

  initial begin
    rst = 1'b0; cpu_wr_cs = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    line_start = 1'b0; line_y = '0;
    for (int i = 0; i < 4096; i++) vmem[i] = 8'h00;
    vmem[12'h7C0] = 8'h29;                       // colour byte
    vmem[12'h440] = 8'h83;                       // row 2 col 0
    vmem[12'h232] = 8'hE4; vmem[12'h233] = 8'h1B;
    vmem[12'h45F] = 8'h41;                       // row 2 col 31: hflip, pmba 1
    vmem[12'h212] = 8'h01; vmem[12'h213] = 8'h80;
    vmem[12'h400] = 8'h63;                       // row 0 col 0: hflip+vflip, pmba 3
    vmem[12'h23E] = 8'hC0; vmem[12'h23F] = 8'h00;
    clear_log();

    run(3);
    check("reset_outputs",
          {26'h0, mem_re, mem_we, bsm_we, fetch_busy, fetch_done, cpu_wr_full}, 32'h0);
    check("reset_overflow", {31'h0, overflow}, 32'h0);
    rst = 1'b1;
    step();

    // uncontended line 17
    start_line(8'd17);
    run(200);
    check("t1_first_re_lat", first_re_cyc - ls_cyc, 1);
    check("t1_done_lat", done_cyc - ls_cyc, 195);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_bsm_cnt", bsm_cnt, 32);
    check("t1_bsm_col0", bsm_mem[0], {3'b101, 16'hE41B});
    check("t1_bsm_col5", bsm_mem[5], {3'b001, 16'h0000});
    check("t1_bsm_col31_hflip", bsm_mem[31], {3'b001, 16'h0240});
    check("t1_busy_after", {31'h0, fetch_busy}, 0);

    // four CPU writes mid-fetch, one to the already fetched tile entry
    t3_addr[0] = 12'h440; t3_data[0] = 8'h00;
    t3_addr[1] = 12'h101; t3_data[1] = 8'h11;
    t3_addr[2] = 12'h102; t3_data[2] = 8'h22;
    t3_addr[3] = 12'h103; t3_data[3] = 8'h33;
    clear_log();
    start_line(8'd17);
    run(19);
    for (int i = 0; i < 4; i++) begin
      cpu_wr_cs = 1'b1; cpu_wr_addr = t3_addr[i]; cpu_wr_data = t3_data[i];
      step();
    end
    cpu_wr_cs = 1'b0;
    run(200);
    check("t3_wr_count", wr_n, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_wr_order%0d", i), wr_log[i], {t3_addr[i], t3_data[i]});
    check("t3_overflow", {31'h0, overflow}, 0);
    check("t3_done_lat_bound",
          {31'h0, (done_cyc - ls_cyc >= 195) && (done_cyc - ls_cyc <= 199)}, 1);
    check("t3_old_tile_used", bsm_mem[0], {3'b101, 16'hE41B});
    check("t3_mem_written", vmem[12'h440], 8'h00);

    // hflip + vflip on line 0
    clear_log();
    start_line(8'd0);
    run(200);
    check("t2_bsm_col0_flip", bsm_mem[0], {3'b001, 16'h0003});
    check("t2_done_lat", done_cyc - ls_cyc, 195);

    // eight back-to-back writes from a wait slot: the 7th meets a full FIFO and is dropped
    clear_log();
    start_line(8'd0);
    run(19);
    for (int i = 0; i < 8; i++) begin
      cpu_wr_cs = 1'b1; cpu_wr_addr = 12'h110 + 12'(i); cpu_wr_data = 8'hB0 + 8'(i);
      step();
    end
    cpu_wr_cs = 1'b0;
    run(200);
    t4_idx[0] = 0; t4_idx[1] = 1; t4_idx[2] = 2; t4_idx[3] = 3;
    t4_idx[4] = 4; t4_idx[5] = 5; t4_idx[6] = 7;
    check("t4_wr_count", wr_n, 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t4_wr_order%0d", i), wr_log[i],
            {12'h110 + 12'(t4_idx[i]), 8'hB0 + 8'(t4_idx[i])});
    check("t4_full_seen", {31'h0, saw_full}, 1);
    check("t4_overflow", {31'h0, overflow}, 1);
    check("t4_dropped_not_written", vmem[12'h116], 8'h00);
    check("t4_done_lat", done_cyc - ls_cyc, 195);

    // line_start during a fetch is ignored
    clear_log();
    start_line(8'd17);
    run(49);
    start_line(8'd0);
    run(200);
    check("t5_single_done", done_cnt, 1);
    check("t5_done_lat", done_cyc - ls_cyc, 195);
    check("t5_line17_kept", bsm_mem[0], {3'b001, 16'h0000});
    check("t5_overflow_sticky", {31'h0, overflow}, 1);

    // reset mid-fetch aborts the line
    start_line(8'd17);
    run(99);
    rst = 1'b0;
    step();
    check("t6_reset_outputs", {28'h0, fetch_busy, mem_re, bsm_we, fetch_done}, 0);
    check("t6_overflow_cleared", {31'h0, overflow}, 0);
    clear_log();
    rst = 1'b1;
    run(200);
    check("t6_no_bsm_after_reset", bsm_cnt, 0);
    check("t6_no_done_after_reset", done_cnt, 0);
    check("t6_idle", {31'h0, fetch_busy}, 0);

    check("never_re_and_we", both_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
